// File: rtl/cast_ejection_port_if.sv
// Flit handshake bundle between router output, ejection port and local PE.
// The slave modport is the ejection port's view of the bundle.
interface cast_ejection_port_if #(
  parameter int unsigned DW = 32
) ();
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          ready_i;

  modport slave (
    input  valid_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o
  );

  modport master (
    output valid_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o
  );
endinterface

// File: rtl/cast_ejection_port.sv
// Cast network ejection port: FWFT flit FIFO toward the PE, packet framing/length
// checks on consumed flits, and one credit pulse per completed packet.
module cast_ejection_port #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH_LOG = 2,
  parameter int unsigned isFC      = 0,
  parameter int unsigned FCpl      = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  cast_ejection_port_if.slave        eject_if,
  output logic                       credit_upd,
  output logic [15:0]                pkt_cnt,
  output logic                       err_proto,
  output logic                       err_len
);
  localparam int unsigned Depth = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PtrOne = (DEPTH_LOG + 1)'(1);
  localparam logic [16:0] FcplLen = 17'(FCpl);
  localparam bit IsFc = (isFC != 0);
  localparam bit SingleLenOk = !IsFc || (FCpl == 1);

  localparam logic [1:0] TypeBody   = 2'b00;
  localparam logic [1:0] TypeHead   = 2'b01;
  localparam logic [1:0] TypeTail   = 2'b10;
  localparam logic [1:0] TypeSingle = 2'b11;

  typedef enum logic {StIdle, StPkt} state_e;

  logic [DW-1:0]    r_mem [Depth];
  logic [DEPTH_LOG:0] r_wptr, r_rptr;
  state_e           r_state, w_state_d;
  logic [15:0]      r_flit_cnt, w_flit_cnt_d;
  logic             r_credit, r_err_proto, r_err_len;
  logic [15:0]      r_pkt_cnt;
  logic             w_full, w_empty, w_wr, w_fire;
  logic [1:0]       w_type;
  logic             w_credit_ev, w_proto_set, w_len_set;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[DEPTH_LOG] != r_rptr[DEPTH_LOG]) &&
                   (r_wptr[DEPTH_LOG-1:0] == r_rptr[DEPTH_LOG-1:0]);
  assign w_wr    = eject_if.valid_i & ~w_full;
  assign w_fire  = ~w_empty & eject_if.ready_i;

  assign eject_if.ready_o = ~w_full;
  assign eject_if.valid_o = ~w_empty;
  assign eject_if.data_o  = r_mem[r_rptr[DEPTH_LOG-1:0]];
  assign w_type           = eject_if.data_o[DW-1 -: 2];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[DEPTH_LOG-1:0]] <= eject_if.data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)   r_wptr <= r_wptr + PtrOne;
      if (w_fire) r_rptr <= r_rptr + PtrOne;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_flit_cnt_d = r_flit_cnt;
    w_credit_ev  = 1'b0;
    w_proto_set  = 1'b0;
    w_len_set    = 1'b0;
    if (w_fire) begin
      case (w_type)
        TypeHead: begin
          // A head inside an open packet abandons it without a credit.
          w_proto_set  = (r_state == StPkt);
          w_state_d    = StPkt;
          w_flit_cnt_d = 16'd1;
        end
        TypeSingle: begin
          w_proto_set  = (r_state == StPkt);
          w_state_d    = StIdle;
          w_flit_cnt_d = 16'd0;
          w_credit_ev  = 1'b1;
          w_len_set    = !SingleLenOk;
        end
        TypeBody: begin
          if (r_state == StPkt) begin
            if (r_flit_cnt != 16'hFFFF) w_flit_cnt_d = r_flit_cnt + 16'd1;
          end else begin
            w_proto_set = 1'b1;
          end
        end
        TypeTail: begin
          if (r_state == StPkt) begin
            w_state_d    = StIdle;
            w_flit_cnt_d = 16'd0;
            w_credit_ev  = 1'b1;
            w_len_set    = IsFc && (({1'b0, r_flit_cnt} + 17'd1) != FcplLen);
          end else begin
            w_proto_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_flit_cnt  <= 16'd0;
      r_credit    <= 1'b0;
      r_pkt_cnt   <= 16'd0;
      r_err_proto <= 1'b0;
      r_err_len   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_flit_cnt <= w_flit_cnt_d;
      r_credit   <= w_credit_ev;
      if (w_credit_ev) r_pkt_cnt   <= r_pkt_cnt + 16'd1;
      if (w_proto_set) r_err_proto <= 1'b1;
      if (w_len_set)   r_err_len   <= 1'b1;
    end
  end

  assign credit_upd = r_credit;
  assign pkt_cnt    = r_pkt_cnt;
  assign err_proto  = r_err_proto;
  assign err_len    = r_err_len;
endmodule
